pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid_pkg.sv | 16 +
 rtl/pipe_entry_reg.sv | 28 ++
 rtl/pipe_stage_skid.sv | 113 +++++++++++
 tb/tb_pipe_stage_skid.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: default widths, the NOP filler word and
// the default-width {pc, idata} payload bundle used between stages.
package pipe_stage_skid_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_PC_W   = 32;

  // RV32 "addi x0, x0, 0", the canonical NOP used to fill bubbles.
  localparam logic [31:0] PIPE_NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [PIPE_PC_W-1:0]   pc;
    logic [PIPE_DATA_W-1:0] idata;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a valid bit plus payload. Clearing the entry also
// overwrites the payload with the fill value, so an empty entry never
// exposes stale data.
module pipe_entry_reg #(
  parameter int unsigned W    = 64,
  parameter logic [W-1:0] FILL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         q_valid,
  output logic [W-1:0] q
);

  // Reset and clear win over load; the top never asserts clr and load together.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q_valid <= 1'b0;
      q       <= FILL;
    end else if (load) begin
      q_valid <= 1'b1;
      q       <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register with a two-entry skid buffer. The main entry drives
// the downstream port; the skid entry catches the one beat that can
// arrive while downstream stalls, so up_ready is a pure register and
// never depends on dn_ready.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned   DATA_W   = PIPE_DATA_W,
  parameter int unsigned   PC_W     = PIPE_PC_W,
  parameter logic [31:0]   NOP_WORD = PIPE_NOP_WORD,
  parameter logic [PC_W-1:0] PC_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_idata,
  input  logic [PC_W-1:0]   up_pc,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_idata,
  output logic [PC_W-1:0]   dn_pc,
  output logic [1:0]        occupancy
);

  localparam int unsigned PAY_W = DATA_W + PC_W;
  // NOP_WORD is a 32-bit constant; the cast truncates or zero-extends it.
  localparam logic [DATA_W-1:0] NOP_FILL = DATA_W'(NOP_WORD);
  localparam logic [PAY_W-1:0]  PAY_FILL = {PC_RST, NOP_FILL};

  logic             main_valid;
  logic             skid_valid;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  logic [PAY_W-1:0] up_pay;

  logic up_fire;
  logic dn_fire;
  logic main_open;
  logic main_load;
  logic main_clr;
  logic skid_load;
  logic skid_clr;
  logic main_next;
  logic skid_next;
  logic [PAY_W-1:0] main_d;

  assign up_pay = {up_pc, up_idata};

  // Handshake decode and next-entry selection.
  always_comb begin
    up_fire   = up_valid & up_ready;
    dn_fire   = main_valid & dn_ready;
    // Main can take a new beat when it is empty or its beat leaves this edge.
    main_open = ~main_valid | dn_fire;

    // Skid always drains first to keep FIFO order. up_fire implies the
    // skid is empty, so the two sources never compete.
    main_load = ~flush & main_open & (skid_valid | up_fire);
    main_d    = skid_valid ? skid_q : up_pay;
    main_clr  = flush | (main_open & ~skid_valid & ~up_fire);

    skid_load = ~flush & ~main_open & up_fire;
    skid_clr  = flush | (main_open & skid_valid);

    main_next = main_load | (main_valid & ~main_clr & ~main_open);
    skid_next = skid_load | (skid_valid & ~skid_clr);
  end

  pipe_entry_reg #(
    .W    (PAY_W),
    .FILL (PAY_FILL)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clr     (main_clr),
    .load    (main_load),
    .d       (main_d),
    .q_valid (main_valid),
    .q       (main_q)
  );

  pipe_entry_reg #(
    .W    (PAY_W),
    .FILL (PAY_FILL)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clr     (skid_clr),
    .load    (skid_load),
    .d       (up_pay),
    .q_valid (skid_valid),
    .q       (skid_q)
  );

  // up_ready and occupancy are registered from the next valid bits so they
  // always match the entry state in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      up_ready  <= ~skid_next;
      occupancy <= {1'b0, main_next} + {1'b0, skid_next};
    end
  end

  assign dn_valid = main_valid;
  assign dn_pc    = main_q[PAY_W-1:DATA_W];
  assign dn_idata = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed scenarios followed by a randomized run, all checked against a
// FIFO model of the stage: up to two beats in flight, oldest on the output.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 64;
  localparam int unsigned PW = 48;
  localparam logic [DW-1:0] NOP64 = 64'h13;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_idata;
  logic [PW-1:0] up_pc;
  logic          dn_valid;
  logic          dn_ready;
  logic [DW-1:0] dn_idata;
  logic [PW-1:0] dn_pc;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [PW-1:0] pc;
  } beat_t;

  beat_t q[$];

  pipe_stage_skid #(
    .DATA_W (DW),
    .PC_W   (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_idata  (up_idata),
    .up_pc     (up_pc),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .dn_idata  (dn_idata),
    .dn_pc     (dn_pc),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the FIFO model.
  task automatic check_model();
    int n;
    n = q.size();
    check("dn_valid", 64'(dn_valid), 64'(n > 0));
    check("dn_idata", 64'(dn_idata), (n > 0) ? 64'(q[0].d) : 64'(NOP64));
    check("dn_pc", 64'(dn_pc), (n > 0) ? 64'(q[0].pc) : 64'd0);
    check("up_ready", 64'(up_ready), 64'(n < 2));
    check("occupancy", 64'(occupancy), 64'(n));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic cycle(input logic rst, input logic fl, input logic uv,
                       input logic [DW-1:0] d, input logic [PW-1:0] p,
                       input logic dr);
    bit upf;
    bit dnf;
    beat_t b;
    reset    = rst;
    flush    = fl;
    up_valid = uv;
    up_idata = d;
    up_pc    = p;
    dn_ready = dr;
    upf = uv && (q.size() < 2);
    dnf = dr && (q.size() > 0);
    b.d  = d;
    b.pc = p;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (dnf) void'(q.pop_front());
      if (upf) q.push_back(b);
      if (fl) q.delete();
    end
    check_model();
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [PW-1:0] rp;
    reset = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
    up_idata = '0; up_pc = '0;

    // Reset then idle.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("rst_dn_valid", 64'(dn_valid), 64'd0);
    check("rst_dn_idata", 64'(dn_idata), 64'h13);
    check("rst_dn_pc", 64'(dn_pc), 64'd0);
    check("rst_up_ready", 64'(up_ready), 64'd1);
    check("rst_occ", 64'(occupancy), 64'd0);

    // Streaming at full rate.
    cycle(0, 0, 1, 64'hA, 48'h0, 1);
    check("str_pc0", 64'(dn_pc), 64'h0);
    cycle(0, 0, 1, 64'hB, 48'h4, 1);
    check("str_pc1", 64'(dn_pc), 64'h4);
    check("str_occ1", 64'(occupancy), 64'd1);
    cycle(0, 0, 1, 64'hC, 48'h8, 1);
    check("str_pc2", 64'(dn_pc), 64'h8);
    check("str_d2", 64'(dn_idata), 64'hC);
    cycle(0, 0, 0, 0, 0, 1);
    check("str_drain", 64'(dn_valid), 64'd0);

    // Backpressure: A held, B in skid, C refused.
    cycle(0, 0, 1, 64'hA, 48'h10, 0);
    cycle(0, 0, 1, 64'hB, 48'h14, 0);
    cycle(0, 0, 1, 64'hC, 48'h18, 0);
    check("bp_hold", 64'(dn_idata), 64'hA);
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_ready", 64'(up_ready), 64'd0);
    cycle(0, 0, 1, 64'hC, 48'h18, 1);
    check("bp_out_b", 64'(dn_idata), 64'hB);
    cycle(0, 0, 1, 64'hC, 48'h18, 1);
    check("bp_out_c", 64'(dn_idata), 64'hC);
    cycle(0, 0, 0, 0, 0, 1);
    check("bp_empty", 64'(occupancy), 64'd0);

    // Flush while full, with a beat offered on the flush edge.
    cycle(0, 0, 1, 64'h111, 48'h20, 0);
    cycle(0, 0, 1, 64'h222, 48'h24, 0);
    cycle(0, 1, 1, 64'h333, 48'h28, 0);
    check("fl_valid", 64'(dn_valid), 64'd0);
    check("fl_idata", 64'(dn_idata), 64'h13);
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_ready", 64'(up_ready), 64'd1);
    cycle(0, 0, 0, 0, 0, 1);
    check("fl_no_emit", 64'(dn_valid), 64'd0);

    // Reset and flush together while full.
    cycle(0, 0, 1, 64'h444, 48'h30, 0);
    cycle(0, 0, 1, 64'h555, 48'h34, 0);
    cycle(1, 1, 1, 64'h666, 48'h38, 1);
    check("rm_valid", 64'(dn_valid), 64'd0);
    check("rm_idata", 64'(dn_idata), 64'h13);
    check("rm_pc", 64'(dn_pc), 64'd0);
    check("rm_occ", 64'(occupancy), 64'd0);
    check("rm_ready", 64'(up_ready), 64'd1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("rm_no_emit", 64'(dn_valid), 64'd0);

    // Randomized valid/ready with rare flush and reset.
    for (int i = 0; i < 10000; i++) begin
      rd = {$urandom, $urandom};
      rp = 48'({$urandom, $urandom});
      cycle(($urandom_range(0, 511) == 0), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0), rd, rp, ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
